// File: rtl/matvec_pkg.sv
// Types and helpers shared by the 3x3 matrix-vector unit and its requantiser.
package matvec_pkg;

    localparam int unsigned DATA_W = 14;
    localparam int unsigned ACC_W  = 28;
    localparam int unsigned ROWS   = 3;

    typedef logic signed [ACC_W-1:0]  acc_t;
    typedef logic signed [DATA_W-1:0] data_t;
    // Working width for requantisation: accumulator plus bias/rounding headroom.
    typedef logic signed [ACC_W+1:0]  wide_t;

    typedef struct packed {
        data_t data;
        logic  clip;
    } sat_t;

    localparam wide_t DATA_MAX = wide_t'(2 ** (DATA_W - 1) - 1);
    localparam wide_t DATA_MIN = wide_t'(-(2 ** (DATA_W - 1)));

    function automatic sat_t sat_to_data(input wide_t v);
        sat_t r;
        if (v > DATA_MAX) begin
            r.data = data_t'(DATA_MAX);
            r.clip = 1'b1;
        end else if (v < DATA_MIN) begin
            r.data = data_t'(DATA_MIN);
            r.clip = 1'b1;
        end else begin
            r.data = data_t'(v);
            r.clip = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Circular result buffer with a registered head entry and occupancy-based full/empty.
module result_fifo #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full      = (count_q == CntW'(DEPTH));
    assign empty     = (count_q == '0);
    assign head_data = head_q;

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;

        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CntW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CntW'(1);
        end

        // Head follows the oldest entry: the incoming one if nothing else is left.
        head_d = head_q;
        if (do_push && (empty || (do_pop && count_q == CntW'(1)))) begin
            head_d = push_data;
        end else if (do_pop && count_q > CntW'(1)) begin
            head_d = mem_q[ptr_inc(rd_ptr_q)];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/matvec_requant.sv
// Requantises the matrix-vector unit's dot products: per-row bias, rounded shift, ReLU,
// saturation, then buffers {data, row, last} for the next layer.
module matvec_requant #(
    parameter int unsigned IN_W       = 28,
    parameter int unsigned OUT_W      = 14,
    parameter int unsigned ROWS       = 3,
    parameter int unsigned SHIFT      = 8,
    parameter int          BIAS0      = 0,
    parameter int          BIAS1      = 0,
    parameter int          BIAS2      = 0,
    parameter int unsigned RELU_EN    = 1,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             input_valid,
    output logic             input_ready,
    input  logic [IN_W-1:0]  input_data,
    output logic             output_valid,
    input  logic             output_ready,
    output logic [OUT_W-1:0] output_data,
    output logic [1:0]       output_row,
    output logic             output_last,
    output logic [7:0]       sat_count
);

    import matvec_pkg::*;

    localparam int unsigned WideW   = IN_W + 2;
    localparam int unsigned EntryW  = OUT_W + 3;
    localparam int unsigned RoundSh = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [WideW-1:0] RoundAdd = (SHIFT > 0) ? (WideW'(1) << RoundSh) : '0;

    logic [1:0]              row_q, row_d;
    logic [7:0]              sat_count_q, sat_count_d;
    logic                    accept, pop, row_last;
    logic                    fifo_full, fifo_empty;
    logic signed [WideW-1:0] bias, biased, rounded, shifted, relu_val;
    sat_t                    sat;
    logic [EntryW-1:0]       entry, head;

    assign row_last     = (row_q == 2'(ROWS - 1));
    // Ready is gated by the reset pin itself so it drops the instant reset asserts.
    assign input_ready  = reset && !fifo_full;
    assign accept       = input_valid && input_ready;
    assign output_valid = !fifo_empty;
    assign pop          = output_valid && output_ready;

    always_comb begin
        unique case (row_q)
            2'd0:    bias = WideW'(BIAS0);
            2'd1:    bias = WideW'(BIAS1);
            default: bias = WideW'(BIAS2);
        endcase
        biased   = WideW'($signed(input_data)) + bias;
        rounded  = biased + RoundAdd;
        shifted  = rounded >>> SHIFT;
        relu_val = ((RELU_EN != 0) && shifted[WideW-1]) ? '0 : shifted;
        sat      = sat_to_data(wide_t'(relu_val));
        entry    = {OUT_W'(sat.data), row_q, row_last};
    end

    always_comb begin
        row_d = row_q;
        if (accept) begin
            row_d = row_last ? 2'd0 : row_q + 2'd1;
        end
        sat_count_d = sat_count_q;
        if (accept && sat.clip && sat_count_q != 8'hFF) begin
            sat_count_d = sat_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_q       <= '0;
            sat_count_q <= '0;
        end else begin
            row_q       <= row_d;
            sat_count_q <= sat_count_d;
        end
    end

    result_fifo #(
        .WIDTH (EntryW),
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept),
        .push_data (entry),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (head)
    );

    assign {output_data, output_row, output_last} = head;
    assign sat_count = sat_count_q;

endmodule

// File: doc/matvec_requant.md
# matvec_requant

Downstream stage of the 3x3 matrix-vector unit. Consumes its stream of 28-bit signed dot products (one per matrix row, rows 0,1,2 repeating), adds a per-row bias, rounds and arithmetic-shifts, applies optional ReLU, and saturates to 14-bit signed. Results are buffered in a small FIFO so that they can drive the next layer's 14-bit `input_data` valid/ready port directly.

## Interface
Parameters:
- `IN_W`, 28: input dot-product width.
- `OUT_W`, 14: output width.
- `ROWS`, 3: results per vector; row counter modulus.
- `SHIFT`, 8: right-shift amount; legal range 0..IN_W-1.
- `BIAS0`/`BIAS1`/`BIAS2`, 0: signed IN_W-bit bias for rows 0/1/2.
- `RELU_EN`, 1: 1 clamps negative results to 0.
- `FIFO_DEPTH`, 2: output buffer entries, ≥2.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `input_valid`  in  1  upstream result valid.
- `input_ready`  out  1  block can accept.
- `input_data`  in  IN_W signed  dot product.
- `output_valid`  out  1  FIFO head valid.
- `output_ready`  in  1  downstream accepts.
- `output_data`  out  OUT_W signed  requantised value.
- `output_row`  out  2  row index of head entry.
- `output_last`  out  1  head entry is row ROWS-1.
- `sat_count`  out  8  count of clipped results, saturates at 255.

## Operation
- Accept (push) when `input_valid && input_ready`. Emit (pop) when `output_valid && output_ready`.
- Row counter: 0 after reset, +1 per accept, wraps ROWS-1 → 0. Each result is tagged with the current row.
- Arithmetic, in IN_W+2 bits, sign-extended:
  - s = input_data + BIAS[row]
  - if SHIFT>0: s += 1<<(SHIFT-1) (round half up)
  - s >>>= SHIFT
- ReLU: if RELU_EN and s<0, s=0.
- Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1] (−8192..8191).
- `sat_count` +1 when saturation changed the value (ReLU clamping does not count). Holds at 255.
- Computation is combinational on the input side. The FIFO entry {data, row, last} is written on accept.
- FIFO: circular, occupancy counter 0..FIFO_DEPTH.
  - `input_ready` = reset deasserted && occupancy<FIFO_DEPTH. No combinational path from `output_ready`.
  - `output_valid` = occupancy>0.
- Push and pop in the same cycle: occupancy unchanged, pointers both advance. Push while full cannot occur. Pop while empty is ignored.
- Head data/row/last are held stable while `output_valid && !output_ready`.

## Timing
- Latency: result accepted at edge N is visible on `output_*` after edge N (`output_valid` high in cycle N+1) if the FIFO was empty.
- Throughput: one result per cycle when downstream is always ready.
- Reset asserted (low), asynchronous:
  - occupancy, pointers, row counter, `sat_count` cleared to 0.
  - `output_valid`=0, `output_data`=0, `output_row`=0, `output_last`=0, `input_ready`=0.
  - Effect is immediate, without waiting for a clock edge.
- Reset deassertion: `input_ready`=1 in the same cycle; the next accepted result is row 0.
- Reset mid-vector discards buffered entries and the partial row count.
- Memory-less otherwise: no state beyond the FIFO, row counter and `sat_count`.

## Structure
- Shared package `matvec_pkg`:
  - `DATA_W`=14, `ACC_W`=28, `ROWS`=3.
  - typedef `acc_t` (signed ACC_W) and `data_t` (signed DATA_W).
  - function `sat_to_data` (saturate, return clip flag).
  - The matrix-vector unit and this block both import it.
- One sub-module: `result_fifo` (parameterised width/depth, async active-low reset, registered head, occupancy-based full/empty).
- Top holds the row counter, bias mux, rounding/shift/ReLU/saturate logic and `sat_count`.

## Test plan
- Defaults, `output_ready`=1, inputs 256, 384, −300:
  - outputs 1, 2, 0; rows 0, 1, 2; `output_last` only on the third; `sat_count`=0.
- Input 134217727 (row 0), then −134217728 (row 1), with RELU_EN=0:
  - outputs 8191, −8192; `sat_count`=2.
- `output_ready`=0, drive 3 valid results:
  - 2 accepted, `input_ready`=0 on the third, which is held upstream.
  - Raise `output_ready`: all 3 emerge in order, no loss or duplication.
- Continuous valid with `output_ready` toggling 1,0,1,0 over 9 results:
  - occupancy never exceeds 2, order preserved, rows cycle 0,1,2 three times.
  - Simultaneous push/pop cycles keep occupancy constant.
- BIAS1=−512, SHIFT=8, inputs 0, 0, 0:
  - outputs 0, 0 (ReLU of −2), 0; with RELU_EN=0 outputs 0, −2, 0.
- After 2 accepted results with 1 buffered, pull `reset` low between edges:
  - `output_valid` drops immediately.
  - After release, input 256 emerges as row 0 with value 1.
